// File: rtl/slos_rec_ctrl_g4.sv
// Gen4 SLOS receive controller: arms the lane 0/1 PRBS11 SLOS checkers, qualifies
// consecutive correctly spaced os_rec pulses per lane and reports lock or timeout.
module slos_rec_ctrl_g4 #(
    parameter int SLOS_LEN       = 448,
    parameter int GAP_SLACK      = 8,
    parameter int REQ_COUNT      = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       lane1_active,
    input  logic       os_rec_l0,
    input  logic       os_rec_l1,
    output logic       rec_en_l0,
    output logic       rec_en_l1,
    output logic       slos_done,
    output logic       slos_fail,
    output logic [2:0] state
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]     GAP_LO     = 11'(SLOS_LEN - GAP_SLACK);
    localparam logic [10:0]     GAP_HI     = 11'(SLOS_LEN + GAP_SLACK);
    localparam logic [10:0]     GAP_LATE   = 11'(SLOS_LEN + GAP_SLACK + 1);
    localparam logic [3:0]      CNT_REQ    = 4'(REQ_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HUNT = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } state_e;

    typedef struct packed {
        logic [3:0] cnt;
        logic [9:0] gap;
    } trk_t;

    // One HUNT cycle of a lane tracker; a locked lane freezes and ignores further pulses.
    function automatic trk_t trk_next(input trk_t cur, input logic pulse);
        trk_t        nxt;
        logic [10:0] gap_inc;
        nxt     = cur;
        gap_inc = {1'b0, cur.gap} + 11'd1;
        if (cur.cnt == CNT_REQ) begin
            nxt = cur;
        end else if (pulse) begin
            nxt.gap = '0;
            if (cur.cnt != '0 && gap_inc >= GAP_LO && gap_inc <= GAP_HI)
                nxt.cnt = cur.cnt + 4'd1;
            else
                nxt.cnt = 4'd1;
        end else if (cur.cnt != '0) begin
            if (gap_inc == GAP_LATE) begin
                nxt.cnt = '0;
                nxt.gap = '0;
            end else begin
                nxt.gap = gap_inc[9:0];
            end
        end
        return nxt;
    endfunction

    state_e        state_q, state_d;
    logic          dual_q, dual_d;
    trk_t          trk0_q, trk0_d, trk1_q, trk1_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rec_en_l0_q, rec_en_l0_d;
    logic          rec_en_l1_q, rec_en_l1_d;
    logic          slos_done_q, slos_done_d;
    logic          slos_fail_q, slos_fail_d;
    logic          lock0, lock1;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        dual_d  = dual_q;
        trk0_d  = '0;
        trk1_d  = '0;
        timer_d = '0;
        lock0   = 1'b0;
        lock1   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                dual_d = lane1_active;
                if (start) state_d = ST_ARM;
            end
            ST_ARM: state_d = ST_HUNT;
            ST_HUNT: begin
                trk0_d  = trk_next(trk0_q, os_rec_l0);
                trk1_d  = dual_q ? trk_next(trk1_q, os_rec_l1) : '0;
                timer_d = timer_q + TW'(1);
                lock0   = (trk0_d.cnt == CNT_REQ);
                lock1   = !dual_q || (trk1_d.cnt == CNT_REQ);
                if (lock0 && lock1)
                    state_d = ST_DONE;
                else if (timer_q == TIMER_LAST)
                    state_d = ST_FAIL;
            end
            ST_DONE, ST_FAIL: state_d = state_q;
            default: state_d = ST_IDLE;
        endcase

        // Dropping start aborts from anywhere and wipes all tracking state.
        if (!start && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            trk0_d  = '0;
            trk1_d  = '0;
            timer_d = '0;
        end

        rec_en_l0_d = (state_d == ST_HUNT);
        rec_en_l1_d = (state_d == ST_HUNT) && dual_d;
        slos_done_d = (state_d == ST_DONE);
        slos_fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dual_q      <= 1'b0;
            trk0_q      <= '0;
            trk1_q      <= '0;
            timer_q     <= '0;
            rec_en_l0_q <= 1'b0;
            rec_en_l1_q <= 1'b0;
            slos_done_q <= 1'b0;
            slos_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dual_q      <= dual_d;
            trk0_q      <= trk0_d;
            trk1_q      <= trk1_d;
            timer_q     <= timer_d;
            rec_en_l0_q <= rec_en_l0_d;
            rec_en_l1_q <= rec_en_l1_d;
            slos_done_q <= slos_done_d;
            slos_fail_q <= slos_fail_d;
        end
    end

    assign rec_en_l0 = rec_en_l0_q;
    assign rec_en_l1 = rec_en_l1_q;
    assign slos_done = slos_done_q;
    assign slos_fail = slos_fail_q;
    assign state     = state_q;

endmodule
